// File: rtl/scroll_up.sv
// rtl/scroll_up.sv - text-mode VRAM scroll engine: moves rows up by one and blanks the bottom row
//
// Purpose: on a scroll request, copies every VRAM cell at address a (a >= COLS) to a-COLS,
// then writes FILL into the last row and pulses o_done. While active it owns the VRAM port.
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_start      scroll request pulse from the putchar stage
//   i_vram_dout  VRAM read data (one cycle after a read)
//   o_running    engine owns the VRAM port
//   o_vram_ce    VRAM chip enable
//   o_vram_w     VRAM write enable (1 = write, 0 = read)
//   o_vram_addr  VRAM address
//   o_vram_din   VRAM write data
//   o_done       one-cycle completion pulse
module scroll_up #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_vram_dout,
    output logic              o_running,
    output logic              o_vram_ce,
    output logic              o_vram_w,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_din,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CLR_START = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              pend_q, pend_d;

    logic              running_q, running_d;
    logic              ce_q, ce_d;
    logic              w_q, w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    // Next-state and pointer logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_READ;
                    src_d   = COLS_A;
                end
            end
            S_READ: begin
                state_d = S_WRITE;
                if (i_start) pend_d = 1'b1;
            end
            S_WRITE: begin
                if (i_start) pend_d = 1'b1;
                if (src_q == LAST) begin
                    state_d = S_CLEAR;
                    dst_d   = CLR_START;
                end else begin
                    state_d = S_READ;
                    src_d   = src_q + ONE;
                end
            end
            S_CLEAR: begin
                if (i_start) pend_d = 1'b1;
                if (dst_q == LAST) state_d = S_DONE;
                else               dst_d   = dst_q + ONE;
            end
            S_DONE: begin
                // A request arriving in the DONE cycle itself is folded into the pending
                // flag so it is not lost on the way back to IDLE.
                pend_d = 1'b0;
                if (pend_q || i_start) begin
                    state_d = S_READ;
                    src_d   = COLS_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        running_d = 1'b0;
        ce_d      = 1'b0;
        w_d       = 1'b0;
        addr_d    = '0;
        done_d    = 1'b0;
        case (state_d)
            S_READ: begin
                running_d = 1'b1;
                ce_d      = 1'b1;
                addr_d    = src_d;
            end
            S_WRITE: begin
                running_d = 1'b1;
                ce_d      = 1'b1;
                w_d       = 1'b1;
                addr_d    = src_d - COLS_A;
            end
            S_CLEAR: begin
                running_d = 1'b1;
                ce_d      = 1'b1;
                w_d       = 1'b1;
                addr_d    = dst_d;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            pend_q    <= 1'b0;
            running_q <= 1'b0;
            ce_q      <= 1'b0;
            w_q       <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            pend_q    <= pend_d;
            running_q <= running_d;
            ce_q      <= ce_d;
            w_q       <= w_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

    // Write data passes the read data straight through so the copy needs no holding register.
    always_comb begin
        o_vram_din = 8'h00;
        case (state_q)
            S_WRITE: o_vram_din = i_vram_dout;
            S_CLEAR: o_vram_din = FILL;
            default: ;
        endcase
    end

    assign o_running   = running_q;
    assign o_vram_ce   = ce_q;
    assign o_vram_w    = w_q;
    assign o_vram_addr = addr_q;
    assign o_done      = done_q;

endmodule
